// File: rtl/network_mac_accum_requant.sv
// -----------------------------------------------------------------------------
// network_mac_accum_requant
//
// Purpose:
//   Sits after the signed multiplier stage of the convolution datapath.
//   It sums TAPS signed products into one output pixel and adds a
//   per-channel bias. The sum is then rounded, right-shifted by SHIFT and
//   saturated to an OUT_WIDTH signed activation.
//
// Optional feature (macro NETWORK_MAC_RELU_EN):
//   defined   - a ReLU follows saturation. A negative result becomes 0 and
//               sat_flag reports only positive clipping.
//   undefined - the output is signed and saturates at both ends.
//
// Ports:
//   ap_clk      in   clock, rising-edge
//   ap_rst      in   asynchronous active-high reset
//   prod_data   in   [PROD_WIDTH-1:0] signed product
//   prod_valid  in   prod_data is valid
//   prod_ready  out  a product is accepted this cycle
//   bias        in   [OUT_WIDTH-1:0] signed bias, sampled with tap 0
//   out_data    out  [OUT_WIDTH-1:0] signed requantised result
//   out_valid   out  out_data is valid
//   out_ready   in   downstream accepts out_data
//   sat_flag    out  result was clipped (valid with out_valid)
//   dbg_state   out  [1:0] current FSM state (0=ACCUM, 1=ROUND, 2=OUT)
//
// Handshake:
//   Both sides use valid/ready. A transfer happens on a rising edge where
//   valid and ready are both high. While valid is high, the source holds its
//   data stable. Ready depends only on registered state, so no combinational
//   path exists from out_ready to prod_ready or from prod_valid to out_valid.
// -----------------------------------------------------------------------------
module network_mac_accum_requant #(
    parameter int PROD_WIDTH = 30,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int TAPS       = 9,
    parameter int SHIFT      = 12
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [OUT_WIDTH-1:0]  bias,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    // TAPS is at most 255, so an 8-bit tap counter is always wide enough.
    localparam logic [7:0] TAPS_M1 = 8'(TAPS - 1);

    // This constant adds half an LSB before the arithmetic shift, so
    // rounding is half toward +infinity.
    localparam logic signed [ACC_WIDTH-1:0] ROUND_K =
        ACC_WIDTH'(64'd1 << (SHIFT - 1));

    // These are the saturation limits, sign-extended to the accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [1:0]                   state;
    logic [7:0]                   tap_cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]         bias_q;
    logic [OUT_WIDTH-1:0]         out_data_q;
    logic                         sat_q;

    logic                         prod_fire;
    logic                         last_tap;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  bias_sh;
    logic signed [ACC_WIDTH-1:0]  t_sum;
    logic signed [ACC_WIDTH-1:0]  r_shift;
    logic [OUT_WIDTH-1:0]         res_data;
    logic                         res_sat;

    // prod_ready is forced low while reset is held. It rises as soon as
    // reset drops, because the state is already ACCUM.
    assign prod_ready = (state == S_ACCUM) && !ap_rst;
    assign out_valid  = (state == S_OUT);
    assign out_data   = out_data_q;
    assign sat_flag   = sat_q;
    assign dbg_state  = state;

    assign prod_fire = prod_valid && prod_ready;
    assign last_tap  = (tap_cnt == TAPS_M1);

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_q[OUT_WIDTH-1]}}, bias_q};
    assign bias_sh  = bias_ext <<< SHIFT;

    // This block computes the requantised result from acc and bias_q. It is
    // registered only in ROUND, and acc and bias_q are stable in that state.
    always_comb begin
        t_sum    = acc + bias_sh + ROUND_K;
        r_shift  = t_sum >>> SHIFT;
        res_data = r_shift[OUT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (r_shift > OUT_MAX) begin
            res_data = OUT_MAX[OUT_WIDTH-1:0];
            res_sat  = 1'b1;
        end else if (r_shift < OUT_MIN) begin
            res_data = OUT_MIN[OUT_WIDTH-1:0];
            res_sat  = 1'b1;
        end
`ifdef NETWORK_MAC_RELU_EN
        // A negative result clamps to zero. Negative clipping is not
        // reported, because the ReLU would have discarded it anyway.
        if (r_shift[ACC_WIDTH-1]) begin
            res_data = '0;
            res_sat  = 1'b0;
        end
`endif
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= S_ACCUM;
            tap_cnt    <= '0;
            acc        <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (prod_fire) begin
                        // Tap 0 starts a fresh sum and latches the channel bias.
                        if (tap_cnt == 8'd0) begin
                            acc    <= prod_ext;
                            bias_q <= bias;
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        if (last_tap) begin
                            tap_cnt <= '0;
                            state   <= S_ROUND;
                        end else begin
                            tap_cnt <= tap_cnt + 8'd1;
                        end
                    end
                end
                S_ROUND: begin
                    out_data_q <= res_data;
                    sat_q      <= res_sat;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_ACCUM;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_mac_accum_requant.sv
// -----------------------------------------------------------------------------
// tb_network_mac_accum_requant
//
// Self-checking bench for network_mac_accum_requant with default parameters
// (TAPS=9, SHIFT=12). Build with or without NETWORK_MAC_RELU_EN; the expected
// values follow the macro.
// -----------------------------------------------------------------------------
module tb_network_mac_accum_requant;

    localparam int PW   = 30;
    localparam int OW   = 16;
    localparam int TAPS = 9;
    localparam int W    = OW + 1;

    // ------------------------------------------------------------ clock/reset
    logic           ap_clk;
    logic           ap_rst;
    logic [PW-1:0]  prod_data;
    logic           prod_valid;
    logic           prod_ready;
    logic [OW-1:0]  bias;
    logic [OW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           sat_flag;
    logic [1:0]     dbg_state;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    network_mac_accum_requant dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------ bookkeeping
    int tests    = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];          // {sat_flag, out_data}
    logic [PW-1:0] grp[TAPS];

    typedef struct {
        logic [PW-1:0] p0;
        logic [PW-1:0] prest;
        logic [OW-1:0] b;
        logic [OW-1:0] exp_d;
        logic          exp_s;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // This is an independent reference model of the arithmetic, using 64-bit
    // integers.
    function automatic logic [W-1:0] model(input logic signed [OW-1:0] b);
        longint sum;
        longint t;
        longint r;
        logic [OW-1:0] d;
        logic s;
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += longint'($signed(grp[i]));
        t = sum + longint'(b) * 4096 + 2048;
        r = t >>> 12;
        s = 1'b0;
        if (r > 32767)       begin d = 16'h7FFF; s = 1'b1; end
        else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
        else                 d = 16'(r);
`ifdef NETWORK_MAC_RELU_EN
        if (r < 0) begin d = '0; s = 1'b0; end
`endif
        return {s, d};
    endfunction

    // ------------------------------------------------------------ driver tasks
    // This task offers one product and returns #1 after the accepting edge.
    task automatic send_prod(input logic [PW-1:0] d, input logic [OW-1:0] b);
        int n;
        n = 0;
        prod_data  = d;
        bias       = b;
        prod_valid = 1'b1;
        @(negedge ap_clk);
        while (!prod_ready && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (!prod_ready) begin
            failures++;
            tests++;
            $display("FAIL prod_accept_timeout: prod_ready stuck 0 at %0t", $time);
        end
        @(posedge ap_clk);
        #1;
        prod_valid = 1'b0;
    endtask

    // This task sends the group in grp[]. Only tap 0 carries the real bias;
    // later taps carry junk bias values, which the DUT must ignore.
    task automatic send_grp(input logic [OW-1:0] b, input bit gaps);
        for (int i = 0; i < TAPS; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    @(posedge ap_clk);
                    #1;
                end
            end
            send_prod(grp[i], (i == 0) ? b : OW'($urandom));
        end
    endtask

    task automatic fill_grp(input logic [PW-1:0] p0, input logic [PW-1:0] prest);
        for (int i = 0; i < TAPS; i++) grp[i] = (i == 0) ? p0 : prest;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!out_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                failures++;
                $display("FAIL unexpected_output: got data 0x%0h sat %0b with empty queue", out_data, sat_flag);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("out_data", {16'd0, out_data}, {16'd0, e[OW-1:0]});
                check("sat_flag", {31'd0, sat_flag}, {31'd0, e[OW]});
            end
        end
    end

    // ------------------------------------------------------------ main test
    initial begin
        logic [OW-1:0] held_d;
        logic          held_s;

        // These are hand-derived vectors {p0, other 8 taps, bias, exp data, exp sat}.
        vecs[0]  = '{30'd4096,     30'd4096,     16'd0,      16'd9,      1'b0};
        vecs[1]  = '{30'd2048,     30'd0,        16'd0,      16'd1,      1'b0};
        vecs[2]  = '{-30'sd2048,   30'd0,        16'd0,      16'd0,      1'b0};
        vecs[3]  = '{30'h1000_0000, 30'h1000_0000, 16'd0,    16'h7FFF,   1'b1};
        vecs[4]  = '{30'd1000,     30'd1000,     16'd100,    16'd102,    1'b0};
        vecs[5]  = '{30'd0,        30'd0,        16'h7FFF,   16'h7FFF,   1'b0};
        vecs[6]  = '{30'd2048,     30'd0,        16'h7FFF,   16'h7FFF,   1'b1};
`ifdef NETWORK_MAC_RELU_EN
        vecs[7]  = '{-30'sd2049,   30'd0,        16'd0,      16'd0,      1'b0};
        vecs[8]  = '{30'h2000_0000, 30'h2000_0000, 16'd0,    16'd0,      1'b0};
        vecs[9]  = '{30'd0,        30'd0,        -16'sd5,    16'd0,      1'b0};
        vecs[10] = '{-30'sd2049,   30'd0,        16'h8000,   16'd0,      1'b0};
`else
        vecs[7]  = '{-30'sd2049,   30'd0,        16'd0,      16'hFFFF,   1'b0};
        vecs[8]  = '{30'h2000_0000, 30'h2000_0000, 16'd0,    16'h8000,   1'b1};
        vecs[9]  = '{30'd0,        30'd0,        -16'sd5,    -16'sd5,    1'b0};
        vecs[10] = '{-30'sd2049,   30'd0,        16'h8000,   16'h8000,   1'b1};
`endif

        ap_rst     = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        bias       = '0;
        out_ready  = 1'b1;

        // This block checks the outputs while reset is held.
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_out_data",   {16'd0, out_data},   32'd0);
        check("rst_sat_flag",   {31'd0, sat_flag},   32'd0);
        check("rst_state",      {30'd0, dbg_state},  32'd0);
        ap_rst = 1'b0;
        #1;
        check("post_rst_prod_ready", {31'd0, prod_ready}, 32'd1);

        // This sequence checks the latency: out_valid must rise 2 edges after
        // the last tap.
        fill_grp(30'd4096, 30'd4096);
        exp_q.push_back({1'b0, 16'd9});
        send_grp(16'd0, 1'b0);
        check("lat_round_state",     {30'd0, dbg_state},  32'd1);
        check("lat_round_no_valid",  {31'd0, out_valid},  32'd0);
        check("lat_round_not_ready", {31'd0, prod_ready}, 32'd0);
        @(posedge ap_clk);
        #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        wait_drain();

        // This loop applies the table-driven vectors, gap-free.
        for (int v = 0; v < NVEC; v++) begin
            fill_grp(vecs[v].p0, vecs[v].prest);
            exp_q.push_back({vecs[v].exp_s, vecs[v].exp_d});
            send_grp(vecs[v].b, 1'b0);
        end
        wait_drain();

        // This block sends random groups twice, once gap-free and once with
        // random prod_valid bubbles. Both must match the model.
        for (int k = 0; k < 4; k++) begin
            logic [OW-1:0] b;
            b = OW'($urandom_range(0, 2000)) - OW'(1000);
            for (int i = 0; i < TAPS; i++)
                grp[i] = PW'($urandom_range(0, 1 << 24)) - PW'(1 << 23);
            exp_q.push_back(model(b));
            send_grp(b, 1'b0);
            exp_q.push_back(model(b));
            send_grp(b, 1'b1);
        end
        wait_drain();

        // This block holds out_ready low in OUT for 5 cycles and checks that
        // the output stays stable.
        out_ready = 1'b0;
        fill_grp(30'd4096, 30'd8192);
        exp_q.push_back({1'b0, 16'd17});
        send_grp(16'd0, 1'b0);
        wait_out_valid();
        held_d = out_data;
        held_s = sat_flag;
        check("bp_first_data", {16'd0, held_d}, 32'd17);
        prod_valid = 1'b1;
        prod_data  = 30'h3FF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            check("bp_valid_held", {31'd0, out_valid},  32'd1);
            check("bp_data_held",  {16'd0, out_data},   {16'd0, held_d});
            check("bp_sat_held",   {31'd0, sat_flag},   {31'd0, held_s});
            check("bp_no_ready",   {31'd0, prod_ready}, 32'd0);
        end
        @(posedge ap_clk);
        #1;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_ready_after_hs", {31'd0, prod_ready}, 32'd1);
        check("bp_valid_after_hs", {31'd0, out_valid},  32'd0);
        wait_drain();

        // This block asserts reset after 4 taps. The reset must discard the
        // partial sum and clear the old output.
        fill_grp(30'd4096, 30'd4096);
        for (int i = 0; i < 4; i++) send_prod(30'd4096, 16'd0);
        ap_rst = 1'b1;
        #1;
        check("mid_rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("mid_rst_out_data",   {16'd0, out_data},   32'd0);
        check("mid_rst_sat_flag",   {31'd0, sat_flag},   32'd0);
        check("mid_rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        exp_q.push_back({1'b0, 16'd9});
        send_grp(16'd0, 1'b0);
        wait_drain();

        repeat (2) @(posedge ap_clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // This is a global watchdog, so the bench always finishes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
